// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default latencies.
// Ops 6/7 (madd/maddu) are only honoured when MDU_MADD_EN is defined.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MADD  = 3'd6,
        MDU_MADDU = 3'd7
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for the latched op and operands.
// Divide by zero and signed overflow are resolved here rather than left to the divider.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               div_zero;
    logic               div_ovf;

    assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u   = {32'b0, a} * {32'b0, b};
    assign div_zero = (b == 32'b0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Divider inputs are forced to safe values on the special cases so no X/trap leaks out.
    always_comb begin
        quot_s = 32'sd0;
        rem_s  = 32'sd0;
        quot_u = 32'd0;
        rem_u  = 32'd0;
        if (!div_zero && !div_ovf) begin
            quot_s = $signed(a) / $signed(b);
            rem_s  = $signed(a) % $signed(b);
        end
        if (!div_zero) begin
            quot_u = a / b;
            rem_u  = a % b;
        end
    end

    always_comb begin
        result = 64'b0;
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV: begin
                if (div_zero)     result = {a, 32'hFFFF_FFFF};
                else if (div_ovf) result = {32'h0000_0000, 32'h8000_0000};
                else              result = {rem_s, quot_s};
            end
            MDU_DIVU: begin
                if (div_zero) result = {a, 32'hFFFF_FFFF};
                else          result = {rem_u, quot_u};
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  result = prod_s;
            MDU_MADDU: result = prod_u;
`endif
            default:   result = 64'b0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and busy/done handshake.
// Define MDU_MADD_EN to enable madd/maddu (ops 6/7) accumulating into {hi,lo}.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [63:0]      arith_res;
    logic [63:0]      commit_val;

    mdu_arith u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (arith_res)
    );

`ifdef MDU_MADD_EN
    // Accumulate against HI/LO as they stand at the commit edge.
    assign commit_val = ((op_q == MDU_MADD) || (op_q == MDU_MADDU)) ?
                        ({hi, lo} + arith_res) : arith_res;
`else
    assign commit_val = arith_res;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 3'b0;
            a_q   <= 32'b0;
            b_q   <= 32'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= 32'b0;
            lo    <= 32'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                op_q  <= op;
                                a_q   <= src_a;
                                b_q   <= src_b;
                                cnt   <= is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                                busy  <= 1'b1;
                                state <= BUSY;
                            end
`ifdef MDU_MADD_EN
                            MDU_MADD, MDU_MADDU: begin
                                op_q  <= op;
                                a_q   <= src_a;
                                b_q   <= src_b;
                                cnt   <= CNT_W'(MULT_CYCLES);
                                busy  <= 1'b1;
                                state <= BUSY;
                            end
`endif
                            MDU_MTHI: hi <= src_a;
                            MDU_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hi    <= commit_val[63:32];
                        lo    <= commit_val[31:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: table of arithmetic vectors plus handshake corner sequences.
// Build with MDU_MADD_EN defined to also exercise madd/maddu.
module tb_mdu;
    import mdu_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pulse start for one edge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] old_hi, old_lo;

        vecs[0] = '{MDU_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
        vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, MC};
        vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
        vecs[3] = '{MDU_DIVU,  32'd10,        32'd0,         32'h0000_000A, 32'hFFFF_FFFF, DC};
        vecs[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DC};
        vecs[5] = '{MDU_DIV,   32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, DC};
        vecs[6] = '{MDU_MULT,  32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A, MC};
        vecs[7] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999, DC};
        vecs[8] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DC};
        vecs[9] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MC};

        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        // Table-driven arithmetic vectors
        for (int i = 0; i < 10; i++) begin
            old_hi = hi;
            old_lo = lo;
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_hold", i), {hi, lo}, {old_hi, old_lo});
            wait_idle(n);
            check($sformatf("v%0d_busy_cycles", i), 64'(n), 64'(vecs[i].cyc));
            check($sformatf("v%0d_done", i), {63'b0, done}, 64'd1);
            check($sformatf("v%0d_hi", i), {32'b0, hi}, {32'b0, vecs[i].exp_hi});
            check($sformatf("v%0d_lo", i), {32'b0, lo}, {32'b0, vecs[i].exp_lo});
            @(negedge clk);
            check($sformatf("v%0d_done_fall", i), {63'b0, done}, 64'd0);
        end

        // Move-to while idle
        issue(MDU_MTLO, 32'h1234, 32'd0);
        check("mtlo_lo", {32'b0, lo}, 64'h1234);
        check("mtlo_busy", {63'b0, busy}, 64'd0);
        issue(MDU_MTHI, 32'h5678, 32'd0);
        check("mthi_hi", {32'b0, hi}, 64'h5678);
        check("mthi_lo_kept", {32'b0, lo}, 64'h1234);

        // mtlo during a div is ignored; operand changes during BUSY have no effect
        issue(MDU_DIV, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b1;
        op    = MDU_MTLO;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        check("busy_mtlo_hold", {hi, lo}, {32'h5678, 32'h1234});
        wait_idle(n);
        check("busy_mtlo_cycles", 64'(n + 2), 64'(DC));
        check("busy_mtlo_result", {hi, lo}, {32'd2, 32'd14});

        // Start on the commit edge is ignored
        issue(MDU_MULT, 32'd3, 32'd3);
        repeat (MC - 1) @(negedge clk);
        check("commit_edge_busy", {63'b0, busy}, 64'd1);
        start = 1'b1;
        op    = MDU_MTHI;
        src_a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        check("commit_edge_busy_fell", {63'b0, busy}, 64'd0);
        check("commit_edge_hilo", {hi, lo}, {32'd0, 32'd9});
        check("commit_edge_done", {63'b0, done}, 64'd1);

`ifndef MDU_MADD_EN
        // Reserved ops do nothing
        issue(MDU_MADD, 32'd1, 32'd1);
        check("reserved6_busy", {63'b0, busy}, 64'd0);
        issue(MDU_MADDU, 32'd1, 32'd1);
        check("reserved7_busy", {63'b0, busy}, 64'd0);
        check("reserved_hilo", {hi, lo}, {32'd0, 32'd9});
`else
        issue(MDU_MTHI, 32'd0, 32'd0);
        issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(MDU_MADDU, 32'd1, 32'd1);
        wait_idle(n);
        check("maddu_cycles", 64'(n), 64'(MC));
        check("maddu_hilo", {hi, lo}, {32'd1, 32'd0});
        issue(MDU_MTHI, 32'd0, 32'd0);
        issue(MDU_MTLO, 32'd5, 32'd0);
        issue(MDU_MADD, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        check("madd_hilo", {hi, lo}, {32'd0, 32'd3});
`endif

        // Reset in the third BUSY cycle aborts without commit
        issue(MDU_MTLO, 32'h55, 32'd0);
        issue(MDU_MULT, 32'd7, 32'd6);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) n++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(n), 64'd0);
        check("abort_hilo_after", {hi, lo}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
